// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command packet sender.
// Optional feature macro used by the importing files: UART_CMD_TWO_STOP_EN.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        CMD_WR      = 2'd0,
        CMD_RD      = 2'd1,
        CMD_ALU_OPR = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_e;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_GAP,
        FS_START,
        FS_DATA,
        FS_PARITY,
        FS_STOP
    } frame_state_e;

    typedef enum logic {
        PKT_IDLE,
        PKT_SEND
    } pkt_state_e;

    localparam logic [7:0] OPC_WR      = 8'hAA;
    localparam logic [7:0] OPC_RD      = 8'hBB;
    localparam logic [7:0] OPC_ALU_OPR = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b10;
    localparam logic [1:0] PAR_ODD  = 2'b11;

    function automatic logic [2:0] frame_count(input cmd_type_e cmd);
        case (cmd)
            CMD_WR:      return 3'd3;
            CMD_RD:      return 3'd2;
            CMD_ALU_OPR: return 3'd4;
            default:     return 3'd2;
        endcase
    endfunction

    function automatic logic [7:0] cmd_opcode(input cmd_type_e cmd);
        case (cmd)
            CMD_WR:      return OPC_WR;
            CMD_RD:      return OPC_RD;
            CMD_ALU_OPR: return OPC_ALU_OPR;
            default:     return OPC_ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/uart_frame_tx.sv
// One-frame UART serializer: idle gap, start, LSB-first data, optional parity, stop.
// UART_CMD_TWO_STOP_EN adds a latched stop2 input selecting two stop bit times.
module uart_frame_tx
    import uart_cmd_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int IDLE_GAP_BITS  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     data,
    input  logic                      par_en,
    input  logic                      par_odd,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
`ifdef UART_CMD_TWO_STOP_EN
    input  logic                      stop2,
`endif
    input  logic                      last,
    output logic                      tx,
    output logic                      done,
    output logic                      last_done
);

    localparam int IDX_W = ($clog2(DATA_WIDTH) > 3) ? $clog2(DATA_WIDTH) : 3;
    localparam frame_state_e FIRST_STATE = (IDLE_GAP_BITS > 0) ? FS_GAP : FS_START;

    frame_state_e              state, nxt_state;
    logic [PRESCALE_WIDTH-1:0] tmr, nxt_tmr, reload_q, reload_in;
    logic [IDX_W-1:0]          idx, nxt_idx, stop_last;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      par_en_q, par_bit_q, last_q;
    logic                      load, bit_end, tx_nxt, done_nxt;

`ifdef UART_CMD_TWO_STOP_EN
    logic stop2_q;
    assign stop_last = stop2_q ? IDX_W'(1) : '0;
`else
    assign stop_last = '0;
`endif

    // Bit timer counts down from P-1, so a zero prescale collapses to one cycle per bit.
    assign reload_in = (prescale == '0) ? '0 : prescale - PRESCALE_WIDTH'(1);
    assign bit_end   = (tmr == '0);

    always_comb begin
        nxt_state = state;
        nxt_tmr   = tmr;
        nxt_idx   = idx;
        load      = 1'b0;
        case (state)
            FS_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    nxt_state = FIRST_STATE;
                    nxt_tmr   = reload_in;
                    nxt_idx   = '0;
                end
            end
            default: begin
                if (!bit_end) begin
                    nxt_tmr = tmr - PRESCALE_WIDTH'(1);
                end else begin
                    nxt_tmr = reload_q;
                    nxt_idx = '0;
                    case (state)
                        FS_GAP: begin
                            if (idx == IDX_W'(IDLE_GAP_BITS - 1)) nxt_state = FS_START;
                            else nxt_idx = idx + IDX_W'(1);
                        end
                        FS_START: nxt_state = FS_DATA;
                        FS_DATA: begin
                            if (idx == IDX_W'(DATA_WIDTH - 1)) nxt_state = par_en_q ? FS_PARITY : FS_STOP;
                            else nxt_idx = idx + IDX_W'(1);
                        end
                        FS_PARITY: nxt_state = FS_STOP;
                        FS_STOP: begin
                            if (idx != stop_last) begin
                                nxt_idx = idx + IDX_W'(1);
                            end else if (start) begin
                                // Chain straight into the next frame with no idle cycle.
                                load      = 1'b1;
                                nxt_state = FIRST_STATE;
                                nxt_tmr   = reload_in;
                            end else begin
                                nxt_state = FS_IDLE;
                            end
                        end
                        default: nxt_state = FS_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        tx_nxt = 1'b1;
        case (nxt_state)
            FS_START:  tx_nxt = 1'b0;
            FS_DATA:   tx_nxt = data_q[nxt_idx];
            FS_PARITY: tx_nxt = par_bit_q;
            default:   tx_nxt = 1'b1;
        endcase
        done_nxt = (nxt_state == FS_STOP) && (nxt_idx == stop_last) && (nxt_tmr == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FS_IDLE;
            tmr       <= '0;
            idx       <= '0;
            reload_q  <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            last_q    <= 1'b0;
`ifdef UART_CMD_TWO_STOP_EN
            stop2_q   <= 1'b0;
`endif
            tx        <= 1'b1;
            done      <= 1'b0;
            last_done <= 1'b0;
        end else begin
            state     <= nxt_state;
            tmr       <= nxt_tmr;
            idx       <= nxt_idx;
            tx        <= tx_nxt;
            done      <= done_nxt;
            last_done <= done_nxt && last_q;
            if (load) begin
                data_q    <= data;
                par_en_q  <= par_en;
                par_bit_q <= (^data) ^ par_odd;
                reload_q  <= reload_in;
                last_q    <= last;
`ifdef UART_CMD_TWO_STOP_EN
                stop2_q   <= stop2;
`endif
            end
        end
    end

endmodule

// File: rtl/uart_cmd_sender.sv
// Host-side UART command packet generator: packet FSM, field mux and frame counter.
// UART_CMD_TWO_STOP_EN adds the STOP2 input (two stop bit times per frame).
module uart_cmd_sender
    import uart_cmd_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int IDLE_GAP_BITS  = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      CMD_VALID,
    output logic                      CMD_READY,
    input  logic [1:0]                CMD_TYPE,
    input  logic [DATA_WIDTH-1:0]     ADDR,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH-1:0]     OP_A,
    input  logic [DATA_WIDTH-1:0]     OP_B,
    input  logic [DATA_WIDTH-1:0]     FUNC,
    input  logic [1:0]                PAR_CFG,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
`ifdef UART_CMD_TWO_STOP_EN
    input  logic                      STOP2,
`endif
    output logic                      TX_OUT,
    output logic                      BUSY,
    output logic                      FRAME_DONE,
    output logic                      PKT_DONE
);

    pkt_state_e                state;
    cmd_type_e                 cmd_q, cmd_sel;
    logic [1:0]                frm_cnt, next_idx;
    logic [DATA_WIDTH-1:0]     addr_q, wdata_q, opa_q, opb_q, func_q, payload;
    logic [1:0]                par_cfg_q, par_sel;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_sel;
    logic                      accept, ftx_start, ftx_last;
    logic                      frame_done, last_done;

    assign accept    = CMD_VALID && (state == PKT_IDLE);
    assign BUSY      = (state == PKT_SEND);
    assign CMD_READY = (state == PKT_IDLE);

    // The first frame starts on the accept cycle, before the latches are loaded,
    // so frame configuration comes straight from the inputs while idle.
    assign cmd_sel      = accept ? cmd_type_e'(CMD_TYPE) : cmd_q;
    assign par_sel      = accept ? PAR_CFG : par_cfg_q;
    assign prescale_sel = accept ? PRESCALE : prescale_q;
    assign next_idx     = accept ? 2'd0 : frm_cnt + 2'd1;
    assign ftx_start    = accept || (BUSY && frame_done && !last_done);
    assign ftx_last     = ({1'b0, next_idx} == (frame_count(cmd_sel) - 3'd1));

    always_comb begin
        payload = '0;
        if (accept) begin
            payload = DATA_WIDTH'(cmd_opcode(cmd_sel));
        end else begin
            case (cmd_q)
                CMD_WR:      payload = (next_idx == 2'd1) ? addr_q : wdata_q;
                CMD_RD:      payload = addr_q;
                CMD_ALU_OPR: begin
                    case (next_idx)
                        2'd1:    payload = opa_q;
                        2'd2:    payload = opb_q;
                        default: payload = func_q;
                    endcase
                end
                default:     payload = func_q;
            endcase
        end
    end

`ifdef UART_CMD_TWO_STOP_EN
    logic stop2_q, stop2_sel;
    assign stop2_sel = accept ? STOP2 : stop2_q;
`endif

    uart_frame_tx #(
        .DATA_WIDTH    (DATA_WIDTH),
        .PRESCALE_WIDTH(PRESCALE_WIDTH),
        .IDLE_GAP_BITS (IDLE_GAP_BITS)
    ) u_frame_tx (
        .clk      (CLK),
        .rst      (RST),
        .start    (ftx_start),
        .data     (payload),
        .par_en   ((par_sel == PAR_EVEN) || (par_sel == PAR_ODD)),
        .par_odd  (par_sel == PAR_ODD),
        .prescale (prescale_sel),
`ifdef UART_CMD_TWO_STOP_EN
        .stop2    (stop2_sel),
`endif
        .last     (ftx_last),
        .tx       (TX_OUT),
        .done     (frame_done),
        .last_done(last_done)
    );

    assign FRAME_DONE = frame_done;
    assign PKT_DONE   = last_done;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= PKT_IDLE;
            frm_cnt    <= '0;
            cmd_q      <= CMD_WR;
            addr_q     <= '0;
            wdata_q    <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            func_q     <= '0;
            par_cfg_q  <= PAR_NONE;
            prescale_q <= '0;
`ifdef UART_CMD_TWO_STOP_EN
            stop2_q    <= 1'b0;
`endif
        end else begin
            case (state)
                PKT_IDLE: begin
                    if (CMD_VALID) begin
                        state      <= PKT_SEND;
                        frm_cnt    <= '0;
                        cmd_q      <= cmd_type_e'(CMD_TYPE);
                        addr_q     <= ADDR;
                        wdata_q    <= WDATA;
                        opa_q      <= OP_A;
                        opb_q      <= OP_B;
                        func_q     <= FUNC;
                        par_cfg_q  <= PAR_CFG;
                        prescale_q <= PRESCALE;
`ifdef UART_CMD_TWO_STOP_EN
                        stop2_q    <= STOP2;
`endif
                    end
                end
                default: begin
                    if (last_done) state <= PKT_IDLE;
                    else if (frame_done) frm_cnt <= frm_cnt + 2'd1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_sender.sv
// Scoreboard bench for uart_cmd_sender; UART_CMD_TWO_STOP_EN enables the two-stop case.
module tb_uart_cmd_sender;

    localparam int GAP = 1;
`ifdef UART_CMD_TWO_STOP_EN
    localparam bit TWO_STOP = 1'b1;
`else
    localparam bit TWO_STOP = 1'b0;
`endif

    logic       CLK = 1'b0, RST = 1'b1, CMD_VALID = 1'b0;
    logic       CMD_READY, TX_OUT, BUSY, FRAME_DONE, PKT_DONE;
    logic [1:0] CMD_TYPE = 2'd0, PAR_CFG = 2'd0;
    logic [7:0] ADDR = 8'h0, WDATA = 8'h0, OP_A = 8'h0, OP_B = 8'h0, FUNC = 8'h0;
    logic [5:0] PRESCALE = 6'd4;
    logic       STOP2 = 1'b0;

    uart_cmd_sender #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6), .IDLE_GAP_BITS(GAP)) dut (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_TYPE(CMD_TYPE), .ADDR(ADDR), .WDATA(WDATA), .OP_A(OP_A), .OP_B(OP_B),
        .FUNC(FUNC), .PAR_CFG(PAR_CFG), .PRESCALE(PRESCALE),
`ifdef UART_CMD_TWO_STOP_EN
        .STOP2(STOP2),
`endif
        .TX_OUT(TX_OUT), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .PKT_DONE(PKT_DONE)
    );

    always #5 CLK = ~CLK;

    int edges = 0;
    always @(posedge CLK) edges <= edges + 1;

    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         acc;
        int         start;
        int         fin;
        int         p;
        logic [7:0] data;
        bit         par_en;
        bit         par;
        bit         last;
    } item_t;

    item_t q[$];
    int    last_acc = 0;

    task automatic push_pkt(input int acc, input logic [1:0] t, input logic [7:0] a, w, oa, ob, f,
                            input logic [1:0] pc, input logic [5:0] pre, input logic s2);
        logic [7:0] fr[$];
        item_t it;
        int p, b, pe, stops;
        case (t)
            2'd0: begin fr.push_back(8'hAA); fr.push_back(a); fr.push_back(w); end
            2'd1: begin fr.push_back(8'hBB); fr.push_back(a); end
            2'd2: begin fr.push_back(8'hCC); fr.push_back(oa); fr.push_back(ob); fr.push_back(f); end
            default: begin fr.push_back(8'hDD); fr.push_back(f); end
        endcase
        p     = (pre == 6'd0) ? 1 : int'(pre);
        pe    = (pc == 2'b10 || pc == 2'b11) ? 1 : 0;
        stops = (TWO_STOP && s2) ? 2 : 1;
        b     = GAP + 1 + 8 + pe + stops;
        for (int i = 0; i < fr.size(); i++) begin
            it.acc    = acc;
            it.start  = i * b * p;
            it.fin    = (i + 1) * b * p;
            it.p      = p;
            it.data   = fr[i];
            it.par_en = (pe != 0);
            it.par    = (^fr[i]) ^ pc[0];
            it.last   = (i == fr.size() - 1);
            q.push_back(it);
        end
    endtask

    function automatic logic exp_bit(input item_t it, input int off);
        int k;
        k = off / it.p;
        if (k < GAP) return 1'b1;
        k -= GAP;
        if (k == 0) return 1'b0;
        k -= 1;
        if (k < 8) return it.data[k];
        k -= 8;
        if (it.par_en && k == 0) return it.par;
        return 1'b1;
    endfunction

    // Monitor: checks every TX cycle against the model and scores each frame at its end.
    bit         ready_pending = 1'b0;
    int         errs = 0, rel, off, kk;
    logic [7:0] cap = 8'h0;
    logic       capp = 1'b0;
    item_t      cur;

    always @(negedge CLK) begin
        if (ready_pending) begin
            check("ready_after_pkt", {30'd0, CMD_READY, BUSY}, 32'h2);
            ready_pending = 1'b0;
        end
        if (RST) begin
            errs = 0;
            cap  = 8'h0;
        end else if (q.size() > 0 && (edges - q[0].acc + 1) > q[0].start) begin
            cur = q[0];
            rel = edges - cur.acc + 1;
            off = rel - cur.start - 1;
            if (TX_OUT !== exp_bit(cur, off)) errs++;
            kk = off / cur.p;
            if (off % cur.p == 0) begin
                if (kk >= GAP + 1 && kk < GAP + 9) cap[kk-GAP-1] = TX_OUT;
                if (cur.par_en && kk == GAP + 9) capp = TX_OUT;
            end
            if (FRAME_DONE || rel >= cur.fin) begin
                check("frame_end_cycle", rel, cur.fin);
                check("frame_byte", {24'd0, cap}, {24'd0, cur.data});
                if (cur.par_en) check("parity_bit", {31'd0, capp}, {31'd0, cur.par});
                check("tx_wave_errs", errs, 0);
                check("pkt_done", {31'd0, PKT_DONE}, {31'd0, cur.last});
                check("busy_in_pkt", {30'd0, BUSY, CMD_READY}, 32'h2);
                errs = 0;
                cap  = 8'h0;
                void'(q.pop_front());
                if (cur.last) ready_pending = 1'b1;
            end else if (PKT_DONE) begin
                check("pkt_done_stray", {31'd0, PKT_DONE}, 32'h0);
            end
        end else if (FRAME_DONE || PKT_DONE) begin
            check("spurious_done", {30'd0, FRAME_DONE, PKT_DONE}, 32'h0);
        end
    end

    task automatic send(input logic [1:0] t, input logic [7:0] a, w, oa, ob, f,
                        input logic [1:0] pc, input logic [5:0] pre, input logic s2);
        int n = 0;
        @(negedge CLK);
        while (!CMD_READY && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        if (!CMD_READY) check("ready_wait", {31'd0, CMD_READY}, 32'h1);
        CMD_TYPE = t; ADDR = a; WDATA = w; OP_A = oa; OP_B = ob; FUNC = f;
        PAR_CFG = pc; PRESCALE = pre; STOP2 = s2;
        CMD_VALID = 1'b1;
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        last_acc = edges;
        push_pkt(edges, t, a, w, oa, ob, f, pc, pre, s2);
        // Disturb every input; the packet in flight must not notice.
        CMD_TYPE = ~t; ADDR = 8'($urandom); WDATA = 8'($urandom); OP_A = 8'($urandom);
        OP_B = 8'($urandom); FUNC = 8'($urandom); PAR_CFG = ~pc; PRESCALE = pre + 6'd3; STOP2 = ~s2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() > 0 || ready_pending) && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (q.size() > 0) check("drain_timeout", q.size(), 0);
        @(negedge CLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check("rst_tx", {31'd0, TX_OUT}, 32'h1);
        check("rst_ready", {31'd0, CMD_READY}, 32'h1);
        check("rst_busy", {31'd0, BUSY}, 32'h0);
        check("rst_dones", {30'd0, FRAME_DONE, PKT_DONE}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // WR even parity, P=4
        send(2'd0, 8'h05, 8'hA6, 8'h00, 8'h00, 8'h00, 2'b10, 6'd4, 1'b0);
        wait_idle();
        // RD odd parity, P=4
        send(2'd1, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 2'b11, 6'd4, 1'b0);
        wait_idle();
        // ALU_OPR no parity, P=4
        send(2'd2, 8'h00, 8'h00, 8'h28, 8'h1E, 8'h01, 2'b00, 6'd4, 1'b0);
        wait_idle();
        // PAR_CFG=01 behaves as no parity
        send(2'd1, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 6'd2, 1'b0);
        wait_idle();

        // Reset during data bit 1 of frame 2 (ADDR=05 makes that bit low)
        send(2'd0, 8'h05, 8'hA6, 8'h00, 8'h00, 8'h00, 2'b10, 6'd4, 1'b0);
        while (edges - last_acc + 1 < 62) @(negedge CLK);
        check("pre_rst_tx", {31'd0, TX_OUT}, 32'h0);
        RST = 1'b1;
        q.delete();
        @(posedge CLK);
        #1;
        check("abort_tx", {31'd0, TX_OUT}, 32'h1);
        check("abort_ready", {31'd0, CMD_READY}, 32'h1);
        check("abort_busy", {31'd0, BUSY}, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        send(2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b10, 6'd4, 1'b0);
        wait_idle();

        // PRESCALE=0 plus a request pulse while busy
        send(2'd1, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 2'b11, 6'd0, 1'b0);
        repeat (5) @(negedge CLK);
        check("busy_before_pulse", {31'd0, BUSY}, 32'h1);
        CMD_VALID = 1'b1;
        CMD_TYPE  = 2'd0;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        wait_idle();
        repeat (40) @(negedge CLK);
        check("idle_after_pulse", {31'd0, BUSY}, 32'h0);

`ifdef UART_CMD_TWO_STOP_EN
        send(2'd1, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 2'b10, 6'd4, 1'b1);
        wait_idle();
`endif

        repeat (5) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
